// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: word type, IV, round constants and the round
// boolean/rotation functions.
package sha256_pkg;

   typedef logic [31:0] word_t;

   localparam int unsigned ROUNDS_DEFAULT = 64;

   localparam word_t IV [8] = '{
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
   };

   localparam word_t K [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
      32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
      32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
      32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
      32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
      32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
      32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
      32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
      32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   function automatic word_t big_sigma0(word_t x);
      return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
   endfunction

   function automatic word_t big_sigma1(word_t x);
      return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
   endfunction

   function automatic word_t ch(word_t x, word_t y, word_t z);
      return (x & y) ^ (~x & z);
   endfunction

   function automatic word_t maj(word_t x, word_t y, word_t z);
      return (x & y) ^ (x & z) ^ (y & z);
   endfunction

endpackage

// File: rtl/compression_sha_if.sv
// Control, round-feedback and working-state bus of the SHA-256 compression
// engine. The digest member exists only when SHA_DIGEST_ADD_EN is defined.
interface compression_sha_if;
   import sha256_pkg::*;

   logic        load;
   logic        enable;
   word_t       w_i;
   word_t       k_i;
   logic [6:0]  round;
   logic        done;
   word_t       a, b, c, d, e, f, g, h;
`ifdef SHA_DIGEST_ADD_EN
   logic [255:0] digest;
`endif

   modport master (
      output load, enable, w_i, k_i,
      input  round, done, a, b, c, d, e, f, g, h
`ifdef SHA_DIGEST_ADD_EN
      , input digest
`endif
   );

   modport slave (
      input  load, enable, w_i, k_i,
      output round, done, a, b, c, d, e, f, g, h
`ifdef SHA_DIGEST_ADD_EN
      , output digest
`endif
   );

endinterface

// File: rtl/sha256_round.sv
// One combinational SHA-256 compression round: current a..h plus W/K in,
// next a..h out.
module sha256_round
   import sha256_pkg::*;
(
   input  word_t a,
   input  word_t b,
   input  word_t c,
   input  word_t d,
   input  word_t e,
   input  word_t f,
   input  word_t g,
   input  word_t h,
   input  word_t w_i,
   input  word_t k_i,
   output word_t a_next,
   output word_t b_next,
   output word_t c_next,
   output word_t d_next,
   output word_t e_next,
   output word_t f_next,
   output word_t g_next,
   output word_t h_next
);

   word_t t1;
   word_t t2;

   always_comb begin
      t1 = h + big_sigma1(e) + ch(e, f, g) + k_i + w_i;
      t2 = big_sigma0(a) + maj(a, b, c);
   end

   assign a_next = t1 + t2;
   assign b_next = a;
   assign c_next = b;
   assign d_next = c;
   assign e_next = d + t1;
   assign f_next = e;
   assign g_next = f;
   assign h_next = g;

endmodule

// File: rtl/compression_sha.sv
// SHA-256 compression engine: working registers a..h plus a saturating round
// counter. SHA_DIGEST_ADD_EN adds the combinational IV+state digest output.
module compression_sha
   import sha256_pkg::*;
#(
   parameter int unsigned ROUNDS = ROUNDS_DEFAULT
) (
   input logic               clk,
   input logic               n_rst,
   compression_sha_if.slave  bus
);

   localparam logic [6:0] LAST = 7'(ROUNDS);

   word_t      state_q  [8];
   word_t      state_d  [8];
   word_t      next_st  [8];
   logic [6:0] round_q;
   logic [6:0] round_d;

   sha256_round u_round (
      .a      (state_q[0]),
      .b      (state_q[1]),
      .c      (state_q[2]),
      .d      (state_q[3]),
      .e      (state_q[4]),
      .f      (state_q[5]),
      .g      (state_q[6]),
      .h      (state_q[7]),
      .w_i    (bus.w_i),
      .k_i    (bus.k_i),
      .a_next (next_st[0]),
      .b_next (next_st[1]),
      .c_next (next_st[2]),
      .d_next (next_st[3]),
      .e_next (next_st[4]),
      .f_next (next_st[5]),
      .g_next (next_st[6]),
      .h_next (next_st[7])
   );

   // Counter saturates at LAST so enables after completion leave everything frozen.
   always_comb begin
      state_d = state_q;
      round_d = round_q;
      if (bus.load) begin
         state_d = IV;
         round_d = '0;
      end else if (bus.enable && (round_q < LAST)) begin
         state_d = next_st;
         round_d = round_q + 7'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (n_rst) begin
         state_q <= IV;
         round_q <= '0;
      end else begin
         state_q <= state_d;
         round_q <= round_d;
      end
   end

   assign bus.round = round_q;
   assign bus.done  = (round_q == LAST);
   assign bus.a     = state_q[0];
   assign bus.b     = state_q[1];
   assign bus.c     = state_q[2];
   assign bus.d     = state_q[3];
   assign bus.e     = state_q[4];
   assign bus.f     = state_q[5];
   assign bus.g     = state_q[6];
   assign bus.h     = state_q[7];

`ifdef SHA_DIGEST_ADD_EN
   assign bus.digest = {IV[0] + state_q[0], IV[1] + state_q[1],
                        IV[2] + state_q[2], IV[3] + state_q[3],
                        IV[4] + state_q[4], IV[5] + state_q[5],
                        IV[6] + state_q[6], IV[7] + state_q[7]};
`endif

endmodule

// File: tb/tb_compression_sha.sv
// Bench for compression_sha: directed vector table, full "abc" block, and
// random runs against a behavioural SHA-256 model.
module tb_compression_sha;
   import sha256_pkg::*;

   typedef logic [7:0][31:0] st_t;  // index 0 = a ... 7 = h

   typedef struct {
      word_t w;
      word_t k;
      st_t   exp;
   } vec_t;

   logic clk = 1'b0;
   logic n_rst;
   always #5 clk = ~clk;

   compression_sha_if bus ();

   compression_sha #(.ROUNDS(64)) dut (
      .clk   (clk),
      .n_rst (n_rst),
      .bus   (bus)
   );

   int   n_checks = 0;
   int   n_fail   = 0;
   st_t  m_st;
   int   m_round;
   word_t wsch [64];
   vec_t vecs [5];
   string names [8] = '{"a", "b", "c", "d", "e", "f", "g", "h"};

   function automatic word_t rotr(word_t x, int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic st_t iv_st();
      return {32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
              32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667};
   endfunction

   function automatic st_t model_round(st_t s, word_t w, word_t k);
      st_t   r;
      word_t t1, t2;
      t1 = s[7] + (rotr(s[4], 6) ^ rotr(s[4], 11) ^ rotr(s[4], 25))
         + ((s[4] & s[5]) ^ (~s[4] & s[6])) + k + w;
      t2 = (rotr(s[0], 2) ^ rotr(s[0], 13) ^ rotr(s[0], 22))
         + ((s[0] & s[1]) ^ (s[0] & s[2]) ^ (s[1] & s[2]));
      r[0] = t1 + t2;
      r[1] = s[0];
      r[2] = s[1];
      r[3] = s[2];
      r[4] = s[3] + t1;
      r[5] = s[4];
      r[6] = s[5];
      r[7] = s[6];
      return r;
   endfunction

   function automatic st_t dut_st();
      return {bus.h, bus.g, bus.f, bus.e, bus.d, bus.c, bus.b, bus.a};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic check_all(input string tag);
      st_t s;
      s = dut_st();
      for (int i = 0; i < 8; i++) check($sformatf("%s %s", tag, names[i]), s[i], m_st[i]);
      check($sformatf("%s round", tag), 32'(bus.round), 32'(m_round));
      check($sformatf("%s done", tag), 32'(bus.done), 32'(m_round == 64));
   endtask

   // Drive one clock with the given controls and advance the model by the same rules.
   task automatic cycle(input logic rst, input logic ld, input logic en,
                        input word_t w, input word_t k);
      n_rst      = rst;
      bus.load   = ld;
      bus.enable = en;
      bus.w_i    = w;
      bus.k_i    = k;
      @(posedge clk);
      #1;
      if (rst || ld) begin
         m_st    = iv_st();
         m_round = 0;
      end else if (en && m_round < 64) begin
         m_st = model_round(m_st, w, k);
         m_round++;
      end
      n_rst      = 1'b0;
      bus.load   = 1'b0;
      bus.enable = 1'b0;
   endtask

   task automatic run_random(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b1, $urandom, $urandom);
   endtask

   initial begin
      st_t   fin;
      st_t   dig_exp;
      int    t;
      word_t s0, s1;

      n_rst = 1'b1; bus.load = 1'b0; bus.enable = 1'b0; bus.w_i = '0; bus.k_i = '0;
      m_st = '0; m_round = 0;

      // "abc" message schedule
      wsch[0] = 32'h61626380;
      for (int i = 1; i < 15; i++) wsch[i] = '0;
      wsch[15] = 32'h00000018;
      for (int i = 16; i < 64; i++) begin
         s0 = rotr(wsch[i-15], 7) ^ rotr(wsch[i-15], 18) ^ (wsch[i-15] >> 3);
         s1 = rotr(wsch[i-2], 17) ^ rotr(wsch[i-2], 19) ^ (wsch[i-2] >> 10);
         wsch[i] = wsch[i-16] + s0 + wsch[i-7] + s1;
      end

      vecs[0].w = 32'h61626380;
      vecs[0].k = 32'h428a2f98;
      vecs[0].exp = {32'h1f83d9ab, 32'h9b05688c, 32'h510e527f, 32'hfa2a4622,
                     32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667, 32'h5d6aebcd};
      vecs[1].w = 32'h0;        vecs[1].k = 32'h0;
      vecs[2].w = 32'hffffffff; vecs[2].k = 32'hffffffff;
      for (int i = 3; i < 5; i++) begin
         vecs[i].w = $urandom;
         vecs[i].k = $urandom;
      end
      for (int i = 1; i < 5; i++) vecs[i].exp = model_round(iv_st(), vecs[i].w, vecs[i].k);

      // Reset, then load, both give the IV state
      cycle(1'b1, 1'b0, 1'b0, '0, '0);
      check_all("reset");
      check("reset a const", bus.a, 32'h6a09e667);
      cycle(1'b0, 1'b0, 1'b1, 32'h12345678, 32'h9abcdef0);
      cycle(1'b0, 1'b1, 1'b0, '0, '0);
      check_all("load");

      // Single-round vector table
      for (int i = 0; i < 5; i++) begin
         cycle(1'b0, 1'b1, 1'b0, '0, '0);
         cycle(1'b0, 1'b0, 1'b1, vecs[i].w, vecs[i].k);
         fin = dut_st();
         for (int j = 0; j < 8; j++) check($sformatf("vec%0d %s", i, names[j]), fin[j], vecs[i].exp[j]);
         check($sformatf("vec%0d round", i), 32'(bus.round), 32'd1);
      end

      // Full "abc" block with random idle gaps
      cycle(1'b0, 1'b1, 1'b0, '0, '0);
      t = 0;
      for (int guard = 0; guard < 400 && t < 64; guard++) begin
         if ($urandom_range(3) == 0) begin
            cycle(1'b0, 1'b0, 1'b0, $urandom, $urandom);
         end else begin
            cycle(1'b0, 1'b0, 1'b1, wsch[t], K[t]);
            t++;
         end
         check("abc round", 32'(bus.round), 32'(t));
      end
      check_all("abc final");
      check("abc a", bus.a, 32'h506e3058);
      dig_exp = {32'hf20015ad, 32'hb410ff61, 32'h96177a9c, 32'hb00361a3,
                 32'h5dae2223, 32'h414140de, 32'h8f01cfea, 32'hba7816bf};
      fin = dut_st();
      for (int j = 0; j < 8; j++) begin
         check($sformatf("abc digest %0d", j), iv_st()[j] + fin[j], dig_exp[j]);
`ifdef SHA_DIGEST_ADD_EN
         check($sformatf("digest port %0d", j), bus.digest[255 - 32*j -: 32], dig_exp[j]);
`endif
      end

      // Saturation after done
      for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 1'b1, $urandom, $urandom);
      check_all("saturate");
      check("saturate a", bus.a, 32'h506e3058);
      check("saturate round", 32'(bus.round), 32'd64);

      // Restart via load together with enable at round 30
      cycle(1'b0, 1'b1, 1'b0, '0, '0);
      run_random(30);
      check_all("pre-load r30");
      cycle(1'b0, 1'b1, 1'b1, $urandom, $urandom);
      check_all("load r30");
      check("load r30 a", bus.a, 32'h6a09e667);

      // Reset together with load at round 30
      run_random(30);
      cycle(1'b1, 1'b1, 1'b1, $urandom, $urandom);
      check_all("reset r30");
      check("reset r30 h", bus.h, 32'h5be0cd19);

      // Hold at round 5 while W/K wiggle
      run_random(5);
      for (int i = 0; i < 20; i++) begin
         cycle(1'b0, 1'b0, 1'b0, $urandom, $urandom);
         check_all("hold");
      end

      // Random message with random enables through to done and beyond
      cycle(1'b0, 1'b1, 1'b0, '0, '0);
      for (int i = 0; i < 150; i++) begin
         cycle(1'b0, 1'b0, ($urandom_range(4) != 0), $urandom, $urandom);
         check_all("random");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/compression_sha.md
Name: compression_sha

Overview:
- SHA-256 compression engine for the miner's computational block. Performs one compression round per enabled clock cycle on working registers a..h.
- Carries its own 64-round counter; the enclosing block uses `round` to index the message schedule W and the constant table K, and feeds back `w_i`/`k_i`.
- Reaches the final working state after 64 rounds and flags completion.

Parameters:
- ROUNDS, 64, number of compression rounds before `done` asserts (fixed at 64 for SHA-256; exposed for test shortening only).

Ports:
- clk  input  1  system clock, all state updates on rising edge
- n_rst  input  1  synchronous reset, active-high
- load  input  1  restart: reload IV, clear round counter
- enable  input  1  perform one round this cycle
- w_i  input  32  message-schedule word W[round]
- k_i  input  32  round constant K[round]
- round  output  7  current round index, 0..ROUNDS
- done  output  1  high when round == ROUNDS
- a, b, c, d, e, f, g, h  output  32 each  registered working variables

Behaviour:
- Reset (n_rst=1 at clock edge): a..h = 6a09e667, bb67ae85, 3c6ef372, a54ff53a, 510e527f, 9b05688c, 1f83d9ab, 5be0cd19; round=0; done=0.
- Priority per edge: n_rst > load > enable > hold.
- load=1: same state as reset (IV, round=0, done=0); enable is ignored that cycle.
- enable=1 with round<ROUNDS: one SHA-256 round using the current w_i, k_i:
  - T1 = h + Σ1(e) + Ch(e,f,g) + k_i + w_i
  - T2 = Σ0(a) + Maj(a,b,c)
  - next state: h←g, g←f, f←e, e←d+T1, d←c, c←b, b←a, a←T1+T2
  - round←round+1
- Σ0(x) = ROTR2^ROTR13^ROTR22; Σ1(x) = ROTR6^ROTR11^ROTR25; Ch = (e&f)^(~e&g); Maj = (a&b)^(a&c)^(b&c).
- All additions are modulo 2^32; carries are discarded.
- Latency: state after round t is visible on a..h the cycle after the enabled edge. Exactly 64 enabled cycles from load reach done.
- done is combinational from round (round==ROUNDS) and is held until load or reset.
- enable while done=1: ignored; state and round hold (no wrap-around).
- enable=0: full hold.
- `round` is combinationally valid for indexing the W/K tables in the same cycle.
- No output is X after reset.

Optional Feature:
- Macro: SHA_DIGEST_ADD_EN.
- Defined: adds output `digest` [255:0] = {IV0+a, IV1+b, …, IV7+h}, combinational, mod 2^32 per word. Meaningful when done=1.
- Undefined: no `digest` port; the enclosing block performs the IV addition itself.

Decomposition:
- Shared package sha256_pkg:
  - IV constants H0..H7 and the 64-entry K constant array
  - functions for Σ0, Σ1, Ch, Maj
  - typedef word_t (logic [31:0])
  - ROUNDS default
- One natural sub-module: sha256_round.
  - Purely combinational.
  - Inputs: a..h, w_i, k_i. Outputs: next a..h.
  - compression_sha wraps it with the state registers and the round counter.

Test Plan:
- Reset: assert n_rst one cycle → a=6a09e667 … h=5be0cd19, round=0, done=0; repeat with load → identical state.
- Single round, message "abc": w_i=61626380, k_i=428a2f98, enable one cycle → a=5d6aebcd, b=6a09e667, c=bb67ae85, d=3c6ef372, e=fa2a4622, f=510e527f, g=9b05688c, h=1f83d9ab, round=1.
- Full "abc" block:
  - Stimulus: drive the correct W[t], K[t] for 64 enabled cycles, with random enable=0 gaps.
  - Response: done=1 and round=64 after the 64th enabled cycle.
  - Checks: a=506e3058; IV+state digest = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad (also checked on `digest` when SHA_DIGEST_ADD_EN is defined).
- Saturation: 10 further enable cycles after done → a..h, round, done unchanged.
- Mid-operation restart:
  - load asserted at round 30 together with enable → IV state, round=0 next cycle.
  - Reset asserted at round 30 together with load → IV state, round=0.
- Hold: enable=0 for 20 cycles at round 5 → no change to any output.
